sd_spi_card_responder: RTL and testbench

Card-side counterpart of the SD-over-SPI bridge. Decodes 48-bit SD SPI-mode command frames arriving on the card's CMD/DAT3/CLK pins and returns R1, R3 and R7 responses on DAT0. It implements the initialization subset CMD0/CMD8/CMD55/ACMD41/CMD58, so the boot SPI driver can be exercised on-board and in simulation without a physical card. Data-block transfers are out of scope; every decoded command is also reported to local logic.

---
 rtl/sd_spi_card_responder.sv | 219 +++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_card_responder
// Description : SD-card side of an SPI-mode link. Decodes 48-bit command
//               frames and answers the init subset (CMD0/8/55/ACMD41/58).
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_card_responder #(
    parameter logic        CRC_CHECK  = 1'b1,
    parameter int          INIT_POLLS = 2,
    parameter logic [31:0] OCR        = 32'h40FF_8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err
);

    localparam logic [7:0] c_init_polls = INIT_POLLS[7:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sck_sync;
    logic [1:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;
    logic        r_sck_prev;
    logic [1:0]  r_window;
    logic [46:0] r_frame;
    logic [5:0]  r_bit_cnt;
    logic [47:0] r_resp;
    logic [5:0]  r_resp_cnt;
    logic        r_idle;
    logic        r_app;
    logic [7:0]  r_poll;

    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_cs_n;
    logic        w_mosi;
    logic [47:0] w_frame_next;
    logic [5:0]  w_idx;
    logic [31:0] w_arg;
    logic [6:0]  w_crc_rx;
    logic [6:0]  w_crc_calc;
    logic        w_end;
    logic        w_crc_mismatch;
    logic        w_crc_bad;
    logic [7:0]  w_poll_inc;
    logic        w_idle_nx;
    logic        w_app_nx;
    logic [7:0]  w_poll_nx;
    logic        w_illegal;
    logic [7:0]  w_r1;
    logic [47:0] w_resp_nx;
    logic [5:0]  w_resp_len;

    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = crc[6] ^ data[i];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    assign w_sck_rise     = r_sck_sync[1] & ~r_sck_prev;
    assign w_sck_fall     = ~r_sck_sync[1] & r_sck_prev;
    assign w_cs_n         = r_cs_sync[1];
    assign w_mosi         = r_mosi_sync[1];
    assign w_frame_next   = {r_frame, w_mosi};
    assign w_idx          = w_frame_next[45:40];
    assign w_arg          = w_frame_next[39:8];
    assign w_crc_rx       = w_frame_next[7:1];
    assign w_end          = w_frame_next[0];
    assign w_crc_calc     = crc7(w_frame_next[47:8]);
    assign w_crc_mismatch = (w_crc_rx != w_crc_calc);
    assign w_crc_bad      = CRC_CHECK & w_crc_mismatch;
    assign w_poll_inc     = (r_poll == 8'hFF) ? r_poll : r_poll + 8'd1;

    // Card state update and response image for the frame completing this cycle
    always_comb begin
        w_idle_nx  = r_idle;
        w_app_nx   = r_app;
        w_poll_nx  = r_poll;
        w_illegal  = 1'b0;
        case (w_idx)
            6'd0: begin
                if (!w_crc_bad) begin
                    w_idle_nx = 1'b1;
                    w_poll_nx = 8'd0;
                end
            end
            6'd8, 6'd55, 6'd58: ;
            6'd41: begin
                if (!r_app) begin
                    w_illegal = 1'b1;
                end else if (!w_crc_bad) begin
                    w_poll_nx = w_poll_inc;
                    if (w_poll_inc >= c_init_polls) begin
                        w_idle_nx = 1'b0;
                    end
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (!w_crc_bad) begin
            w_app_nx = (w_idx == 6'd55);
        end
        w_r1       = {4'b0000, w_crc_bad, w_illegal, 1'b0, w_idle_nx};
        w_resp_nx  = {8'hFF, w_r1, 32'hFFFF_FFFF};
        w_resp_len = 6'd16;
        if (!w_crc_bad && (w_idx == 6'd8)) begin
            w_resp_nx  = {8'hFF, w_r1, 16'h0000, 4'h0, w_arg[11:8], w_arg[7:0]};
            w_resp_len = 6'd48;
        end else if (!w_crc_bad && (w_idx == 6'd58)) begin
            w_resp_nx  = {8'hFF, w_r1, ~w_idle_nx, OCR[30:0]};
            w_resp_len = 6'd48;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_sck_sync  <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sck_prev  <= 1'b0;
            r_window    <= 2'b11;
            r_frame     <= '0;
            r_bit_cnt   <= 6'd0;
            r_resp      <= '1;
            r_resp_cnt  <= 6'd0;
            r_idle      <= 1'b1;
            r_app       <= 1'b0;
            r_poll      <= 8'd0;
            spi_miso    <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_index   <= 6'd0;
            cmd_arg     <= 32'd0;
            crc_err     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], spi_sck};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_sck_prev  <= r_sck_sync[1];
            cmd_valid   <= 1'b0;
            if (w_cs_n) begin
                r_state  <= S_IDLE;
                r_window <= 2'b11;
                spi_miso <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        spi_miso <= 1'b1;
                        if (w_sck_rise) begin
                            r_window <= {r_window[0], w_mosi};
                            if ({r_window[0], w_mosi} == 2'b01) begin
                                r_state   <= S_RECV;
                                r_frame   <= {45'd0, 2'b01};
                                r_bit_cnt <= 6'd2;
                            end
                        end
                    end
                    S_RECV: begin
                        if (w_sck_rise) begin
                            r_frame   <= w_frame_next[46:0];
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                            if (r_bit_cnt == 6'd47) begin
                                r_window <= 2'b11;
                                if (!w_end) begin
                                    r_state <= S_IDLE;
                                end else begin
                                    cmd_valid  <= 1'b1;
                                    cmd_index  <= w_idx;
                                    cmd_arg    <= w_arg;
                                    crc_err    <= w_crc_mismatch;
                                    r_idle     <= w_idle_nx;
                                    r_app      <= w_app_nx;
                                    r_poll     <= w_poll_nx;
                                    r_resp     <= w_resp_nx;
                                    r_resp_cnt <= w_resp_len;
                                    r_state    <= S_RESP;
                                end
                            end
                        end
                    end
                    S_RESP: begin
                        if (w_sck_fall) begin
                            if (r_resp_cnt != 6'd0) begin
                                spi_miso   <= r_resp[47];
                                r_resp     <= {r_resp[46:0], 1'b1};
                                r_resp_cnt <= r_resp_cnt - 6'd1;
                            end else begin
                                spi_miso <= 1'b1;
                                r_state  <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_spi_card_responder
// Description : Randomized self-checking bench with a card-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_card_responder;

    localparam int          INIT_POLLS = 2;
    localparam logic [31:0] OCR        = 32'h40FF_8000;
    localparam int          HALF       = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b1;
    logic        spi_miso;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_err;

    sd_spi_card_responder #(
        .CRC_CHECK  (1'b1),
        .INIT_POLLS (INIT_POLLS),
        .OCR        (OCR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .crc_err   (crc_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [38:0] exp_q[$];   // {index, arg, crc mismatch} of each expected decode

    bit m_idle = 1'b1;
    bit m_app  = 1'b0;
    int m_poll = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1
    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [7:0] good_crc(input logic [5:0] idx, input logic [31:0] arg);
        return {crc7_model({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok,
                             output logic [47:0] resp);
        bit          legal;
        logic [7:0]  r1;
        logic [31:0] ocr;
        legal = (idx == 0) || (idx == 8) || (idx == 55) || (idx == 58) || (idx == 41 && m_app);
        if (crc_ok) begin
            if (idx == 0) begin
                m_idle = 1'b1;
                m_poll = 0;
            end
            if (idx == 41 && m_app) begin
                if (m_poll < 255) m_poll++;
                if (m_poll >= INIT_POLLS) m_idle = 1'b0;
            end
            m_app = (idx == 55);
        end
        r1   = {4'b0, !crc_ok, !legal, 1'b0, m_idle};
        resp = {8'hFF, r1, 32'hFFFF_FFFF};
        if (crc_ok && idx == 8) resp = {8'hFF, r1, 16'h0000, 4'h0, arg[11:8], arg[7:0]};
        if (crc_ok && idx == 58) begin
            ocr     = OCR;
            ocr[31] = !m_idle;
            resp    = {8'hFF, r1, ocr};
        end
    endtask

    task automatic sck_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        #(HALF);
        spi_sck = 1'b1;
        mi = spi_miso;
        #(HALF);
        spi_sck = 1'b0;
    endtask

    // Full transaction: frame, expected response bytes, one trailing idle byte
    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] cb,
                          output logic [47:0] exp);
        logic [47:0] fr;
        logic [47:0] got;
        logic [7:0]  trail;
        logic        mi;
        bit          crc_ok;
        int          nb;
        fr     = {2'b01, idx, arg, cb};
        crc_ok = (cb[7:1] == crc7_model({2'b01, idx, arg}));
        exp    = '1;
        nb     = 2;
        if (cb[0]) begin
            model_cmd(idx, arg, crc_ok, exp);
            exp_q.push_back({idx, arg, !crc_ok});
            if (crc_ok && (idx == 8 || idx == 58)) nb = 6;
        end
        for (int i = 47; i >= 0; i--) sck_bit(fr[i], mi);
        got = '1;
        for (int i = 0; i < nb * 8; i++) begin
            sck_bit(1'b1, mi);
            got[47 - i] = mi;
        end
        for (int i = 0; i < 8; i++) begin
            sck_bit(1'b1, mi);
            trail[7 - i] = mi;
        end
        chk($sformatf("resp cmd%0d", idx), got, exp);
        chk("miso idle after resp", {40'd0, trail}, 48'hFF);
        chk("pending cmd_valid", 48'(exp_q.size()), 48'd0);
    endtask

    task automatic directed(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] cb,
                            input logic [47:0] lit);
        logic [47:0] exp;
        do_cmd(idx, arg, cb, exp);
        chk($sformatf("model pin cmd%0d", idx), exp, lit);
    endtask

    task automatic cs_abort(input int nbits);
        logic [47:0] fr;
        logic        mi;
        fr = {2'b01, 6'd0, 32'd0, good_crc(6'd0, 32'd0)};
        for (int i = 47; i > 47 - nbits; i--) sck_bit(fr[i], mi);
        spi_cs_n = 1'b1;
        #(HALF * 6);
        chk("miso high with cs high", {47'd0, spi_miso}, 48'd1);
        spi_cs_n = 1'b0;
        #(HALF * 2);
    endtask

    // Decode monitor: every cmd_valid pulse must match the next expected frame
    initial begin
        logic        prev;
        logic [38:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && cmd_valid) begin
                chk("cmd_valid single pulse", {47'd0, prev}, 48'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected cmd_valid: actual index %0d required none", cmd_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_index", {42'd0, cmd_index}, {42'd0, e[38:33]});
                    chk("cmd_arg", {16'd0, cmd_arg}, {16'd0, e[32:1]});
                    chk("crc_err", {47'd0, crc_err}, {47'd0, e[0]});
                end
            end
            prev = reset_n ? cmd_valid : 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] fr;
        logic [47:0] exp;
        logic        mi;
        #3;
        #40;
        chk("reset miso", {47'd0, spi_miso}, 48'd1);
        chk("reset cmd_valid", {47'd0, cmd_valid}, 48'd0);
        chk("reset cmd_index", {42'd0, cmd_index}, 48'd0);
        chk("reset cmd_arg", {16'd0, cmd_arg}, 48'd0);
        chk("reset crc_err", {47'd0, crc_err}, 48'd0);
        chk("crc model cmd0", {41'd0, crc7_model(40'h40_0000_0000)}, 48'h4A);
        chk("crc model cmd8", {41'd0, crc7_model(40'h48_0000_01AA)}, 48'h43);
        reset_n = 1'b1;
        #100;
        spi_cs_n = 1'b0;
        #100;

        directed(6'd0,  32'h0,         8'h95, {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd8,  32'h0000_01AA, 8'h87, 48'hFF01_0000_01AA);
        directed(6'd55, 32'h0,         good_crc(6'd55, 32'h0), {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd41, 32'h4000_0000, good_crc(6'd41, 32'h4000_0000), {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd0,  32'h0,         8'h01, {16'hFF09, 32'hFFFF_FFFF});
        directed(6'd55, 32'h0,         good_crc(6'd55, 32'h0), {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd41, 32'h4000_0000, good_crc(6'd41, 32'h4000_0000), {16'hFF00, 32'hFFFF_FFFF});
        directed(6'd58, 32'h0,         good_crc(6'd58, 32'h0), 48'hFF00_C0FF_8000);
        directed(6'd0,  32'h0,         8'h95, {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd17, 32'h0,         good_crc(6'd17, 32'h0), {16'hFF05, 32'hFFFF_FFFF});
        directed(6'd41, 32'h4000_0000, good_crc(6'd41, 32'h4000_0000), {16'hFF05, 32'hFFFF_FFFF});
        cs_abort(20);
        directed(6'd0,  32'h0,         8'h95, {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd8,  32'h1234_5678, 8'h86, {16'hFFFF, 32'hFFFF_FFFF});

        // Reach ready, then reset in the middle of a response
        directed(6'd55, 32'h0, good_crc(6'd55, 32'h0), {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd41, 32'h0, good_crc(6'd41, 32'h0), {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd55, 32'h0, good_crc(6'd55, 32'h0), {16'hFF01, 32'hFFFF_FFFF});
        directed(6'd41, 32'h0, good_crc(6'd41, 32'h0), {16'hFF00, 32'hFFFF_FFFF});
        fr = {2'b01, 6'd8, 32'h0000_0155, good_crc(6'd8, 32'h0000_0155)};
        model_cmd(6'd8, 32'h0000_0155, 1'b1, exp);
        exp_q.push_back({6'd8, 32'h0000_0155, 1'b0});
        for (int i = 47; i >= 0; i--) sck_bit(fr[i], mi);
        for (int i = 0; i < 12; i++) sck_bit(1'b1, mi);
        reset_n = 1'b0;
        #1;
        chk("async reset miso", {47'd0, spi_miso}, 48'd1);
        chk("async reset cmd_index", {42'd0, cmd_index}, 48'd0);
        chk("async reset cmd_arg", {16'd0, cmd_arg}, 48'd0);
        chk("cmd8 pulse before reset", 48'(exp_q.size()), 48'd0);
        m_idle = 1'b1;
        m_app  = 1'b0;
        m_poll = 0;
        #49;
        reset_n = 1'b1;
        #100;
        directed(6'd58, 32'h0, good_crc(6'd58, 32'h0), 48'hFF01_40FF_8000);

        for (int t = 0; t < 30; t++) begin
            logic [5:0]  idx;
            logic [31:0] arg;
            logic [7:0]  cb;
            int          k;
            k = $urandom_range(0, 11);
            case (k)
                0:       idx = 6'd0;
                1:       idx = 6'd8;
                2, 3:    idx = 6'd55;
                4, 5:    idx = 6'd41;
                6:       idx = 6'd58;
                7:       idx = 6'd17;
                default: idx = 6'($urandom_range(0, 63));
            endcase
            arg = $urandom;
            cb  = good_crc(idx, arg);
            k   = $urandom_range(0, 19);
            if (k == 0) cb[0] = 1'b0;
            else if (k < 3) cb[7:1] = cb[7:1] ^ 7'(1 << $urandom_range(0, 6));
            if (k == 3) cs_abort($urandom_range(1, 47));
            do_cmd(idx, arg, cb, exp);
        end

        #200;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
